// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - 32 x 32-bit register file, two combinational reads, one synchronous write
//
// Purpose:
//   Integer register file for the 5-stage pipeline. Two read ports (rs, rt) feed ID.
//   One write port is the storage end of the WB write bus. Register 0 always reads zero.
//   There is no internal read-after-write bypass. A read of the register being written
//   returns the old value until the edge. The WB forwarding mux outside handles that case.
//
// Ports:
//   clk            in   1       pipeline clock, rising-edge
//   reset_n        in   1       asynchronous active-low reset, clears all registers
//   RegWrite       in   1       write enable from WB
//   WriteRegister  in   ADDR_W  write address from WB
//   WriteData      in   DATA_W  write data from WB
//   rs             in   ADDR_W  read address, port 1
//   rt             in   ADDR_W  read address, port 2
//   ReadData1      out  DATA_W  reg[rs], combinational
//   ReadData2      out  DATA_W  reg[rt], combinational
//
// Optional feature, macro RF_DEBUG_PORT_EN:
//   DbgAddr        in   ADDR_W  observation-only read address
//   DbgData        out  DATA_W  reg[DbgAddr], combinational
//   WrCount        out  32      committed-write counter, wraps, cleared by reset

module reg_file_2r1w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
`ifdef RF_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [DATA_W-1:0] DbgData,
  output logic [31:0]       WrCount
`endif
);

  logic [DATA_W-1:0] regBank [NUM_REGS];
  logic              wrEn;

  // A write to register 0 is discarded so that it can never hold a non-zero value.
  assign wrEn = RegWrite && (WriteRegister != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regBank[i] <= '0;
      end
    end else if (wrEn) begin
      regBank[WriteRegister] <= WriteData;
    end
  end

  // Address 0 is forced to zero on the read side as well. Register 0 then reads zero
  // even before the first reset has cleared the array.
  assign ReadData1 = (rs == '0) ? '0 : regBank[rs];
  assign ReadData2 = (rt == '0) ? '0 : regBank[rt];

`ifdef RF_DEBUG_PORT_EN
  logic [31:0] wrCount;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrCount <= '0;
    end else if (wrEn) begin
      wrCount <= wrCount + 32'd1;
    end
  end

  assign DbgData = (DbgAddr == '0) ? '0 : regBank[DbgAddr];
  assign WrCount = wrCount;
`endif

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - self-checking bench for reg_file_2r1w

module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  WriteRegister = '0;
  logic [31:0] WriteData = '0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
`ifdef RF_DEBUG_PORT_EN
  logic [4:0]  DbgAddr = '0;
  logic [31:0] DbgData;
  logic [31:0] WrCount;
`endif

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  // Reference contents: what each architectural register must hold.
  logic [31:0] model [32];
`ifdef RF_DEBUG_PORT_EN
  logic [31:0] modelWrCount = '0;
`endif

  reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .rs            (rs),
    .rt            (rt),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
`ifdef RF_DEBUG_PORT_EN
    ,
    .DbgAddr       (DbgAddr),
    .DbgData       (DbgData),
    .WrCount       (WrCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Reset empties every register. A committed write stores data
  // unless the target is register 0.
  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) model[i] <= '0;
`ifdef RF_DEBUG_PORT_EN
      modelWrCount <= '0;
`endif
    end else if (RegWrite && WriteRegister != 5'd0) begin
      model[WriteRegister] <= WriteData;
`ifdef RF_DEBUG_PORT_EN
      modelWrCount <= modelWrCount + 32'd1;
`endif
    end
  end

  // Check every falling edge, away from the write edge.
  always @(negedge clk) begin
    if (checkEn) begin
      check("cyc_rd1", ReadData1, model[rs]);
      check("cyc_rd2", ReadData2, model[rt]);
`ifdef RF_DEBUG_PORT_EN
      check("cyc_dbg", DbgData, model[DbgAddr]);
      check("cyc_wrcount", WrCount, modelWrCount);
`endif
    end
  end

  // Inputs change 1 ns after a rising edge and are sampled at the following rising edge.
  task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    RegWrite      = we;
    WriteRegister = a;
    WriteData     = d;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset held across two edges, then released between edges.
    #23;
    reset_n = 1'b1;
    checkEn = 1'b1;

    // Reset state of registers
    rs = 5'd1; rt = 5'd31; #1;
    check("reset_r1", ReadData1, 32'h0);
    check("reset_r31", ReadData2, 32'h0);

    // Basic write and read
    drive(1'b1, 5'd7, 32'h12345678);
    idle();
    rs = 5'd7; rt = 5'd7; #1;
    check("basic_rd1", ReadData1, 32'h12345678);
    check("basic_rd2", ReadData2, 32'h12345678);
`ifdef RF_DEBUG_PORT_EN
    check("basic_wrcount", WrCount, 32'd1);
`endif

    // Write to register 0 is dropped
    drive(1'b1, 5'd0, 32'hFFFFFFFF);
    idle();
    rs = 5'd0; #1;
    check("x0_rd", ReadData1, 32'h0);
`ifdef RF_DEBUG_PORT_EN
    check("x0_wrcount", WrCount, 32'd1);
`endif

    // Collision: the old value is returned until the edge
    drive(1'b1, 5'd3, 32'hAAAA0000);
    drive(1'b1, 5'd3, 32'h00005555);
    rs = 5'd3; #1;
    check("coll_before", ReadData1, 32'hAAAA0000);
    idle();
    #1;
    check("coll_after", ReadData1, 32'h00005555);

    // Disabled write leaves register 9 untouched
    drive(1'b0, 5'd9, 32'h1);
    idle();
    rs = 5'd9; #1;
    check("dis_r9", ReadData1, 32'h0);

    // Several distinct patterns, including all-ones, alternating bits and the top register
    drive(1'b1, 5'd1, 32'hFFFFFFFF);
    drive(1'b1, 5'd31, 32'hA5A5A5A5);
    drive(1'b1, 5'd16, 32'h5A5A5A5A);
    drive(1'b1, 5'd1, 32'h00000001);
    idle();
    rs = 5'd1; rt = 5'd31; #1;
    check("pat_r1", ReadData1, 32'h00000001);
    check("pat_r31", ReadData2, 32'hA5A5A5A5);
    rs = 5'd16; rt = 5'd7; #1;
    check("pat_r16", ReadData1, 32'h5A5A5A5A);
    check("pat_r7", ReadData2, 32'h12345678);

    // Asynchronous reset in mid-cycle, with a write pending across the held reset
    drive(1'b1, 5'd5, 32'hDEADBEEF);
    idle();
    rs = 5'd5; #1;
    check("pre_reset_r5", ReadData1, 32'hDEADBEEF);
    RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'h00001234;
    reset_n = 1'b0;
    #1;
    check("async_reset_r5", ReadData1, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i); rt = 5'(31 - i);
      #1;
      check("reset_all_rd1", ReadData1, 32'h0);
      check("reset_all_rd2", ReadData2, 32'h0);
    end
`ifdef RF_DEBUG_PORT_EN
    check("reset_wrcount", WrCount, 32'd0);
`endif
    // The write still pending commits on the first edge after release.
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    rs = 5'd5; rt = 5'd7; #1;
    check("post_reset_r5", ReadData1, 32'h00001234);
    check("post_reset_r7", ReadData2, 32'h0);

`ifdef RF_DEBUG_PORT_EN
    // The counter wraps, and the debug port shows register 31
    @(posedge clk);
    #1;
    force dut.wrCount = 32'hFFFFFFFF;
    modelWrCount = 32'hFFFFFFFF;
    #1;
    release dut.wrCount;
    drive(1'b1, 5'd31, 32'hC0FFEE31);
    idle();
    DbgAddr = 5'd31; #1;
    check("dbg_wrap", WrCount, 32'd0);
    check("dbg_r31", DbgData, 32'hC0FFEE31);
    DbgAddr = 5'd0; #1;
    check("dbg_r0", DbgData, 32'h0);
`endif

    repeat (2) @(posedge clk);
    #1;
    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
